// File: rtl/alu_pipe.sv
// Handshaked ALU with a 1-cycle result path and an iterative signed multiplier.
// MUL is built only with ALU_MUL_EN; it takes WIDTH+1 cycles. Results are held until out_ready.
module alu_pipe #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             started_q, started_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] op_res;
  logic             op_ovf;

  assign in_ready  = started_q && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign overflow  = ovf_q;

  // Single-cycle operations; 111 here is the marker used when no multiplier is built.
  always_comb begin
    op_res = '0;
    op_ovf = 1'b0;
    case (alu_op)
      3'b000: op_res = operand1 & operand2;
      3'b001: op_res = operand1 | operand2;
      3'b010: op_res = operand1 ^ operand2;
      3'b011: op_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      3'b100: op_res = $signed(operand1) >>> operand2[SHAMT_W-1:0];
      3'b101: begin
        op_res = operand1 + operand2;
        op_ovf = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (op_res[WIDTH-1] != operand1[WIDTH-1]);
      end
      3'b110: begin
        op_res = operand1 - operand2;
        op_ovf = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (op_res[WIDTH-1] != operand1[WIDTH-1]);
      end
      default: begin
        op_res = '0;
        op_ovf = 1'b1;
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;

  logic [WIDTH:0]     a_ext, abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic               mul_ovf;

  assign is_mul = (alu_op == 3'b111);
  assign busy   = (state_q == S_MUL);

  // |A| carries one extra bit so the most-negative operand stays exact.
  assign a_ext    = {operand1[WIDTH-1], operand1};
  assign abs_a    = operand1[WIDTH-1] ? -a_ext : a_ext;
  assign abs_b    = operand2[WIDTH-1] ? -operand2 : operand2;
  assign acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign prod     = sign_q ? -acc_step : acc_step;
  assign mul_ovf  = (prod[2*WIDTH-1:WIDTH-1] != '0) && (prod[2*WIDTH-1:WIDTH-1] != '1);
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    started_d   = 1'b1;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    ovf_d       = ovf_q;
`ifdef ALU_MUL_EN
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      alu_out_d   = op_res;
      ovf_d       = op_ovf;
    end

`ifdef ALU_MUL_EN
    if (accept && is_mul) begin
      state_d = S_MUL;
      acc_d   = '0;
      mcand_d = {{(WIDTH-1){1'b0}}, abs_a};
      mplr_d  = abs_b;
      sign_d  = operand1[WIDTH-1] ^ operand2[WIDTH-1];
      cnt_d   = CNT_W'(WIDTH);
    end

    // The last shift-add step and the sign fix-up land on the same edge.
    if (state_q == S_MUL) begin
      acc_d   = acc_step;
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_d     = S_IDLE;
        out_valid_d = 1'b1;
        alu_out_d   = prod[WIDTH-1:0];
        ovf_d       = mul_ovf;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      started_q   <= 1'b0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      started_q   <= started_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: expectations are queued at accept and compared on output.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [2:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic        overflow;
  logic        busy;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .operand1(operand1), .operand2(operand2), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .overflow(overflow), .busy(busy)
  );

  typedef struct packed {
    logic        ovf;
    logic [31:0] res;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model in 64-bit arithmetic: overflow means "outside the 32-bit signed range".
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t               e;
    longint             sa, sb, r;
    logic signed [31:0] a_s;
    sa    = $signed(a);
    sb    = $signed(b);
    a_s   = a;
    r     = 0;
    e.res = '0;
    e.ovf = 1'b0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: e.res = a ^ b;
      3'd3: e.res = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: e.res = a_s >>> b[4:0];
      3'd5: begin
        r     = sa + sb;
        e.res = r[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      3'd6: begin
        r     = sa - sb;
        e.res = r[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      default: begin
`ifdef ALU_MUL_EN
        r     = sa * sb;
        e.res = r[31:0];
        e.ovf = (r != longint'($signed(e.res)));
`else
        e.res = '0;
        e.ovf = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_res"}, 64'(alu_out), 64'(e.res));
      check({tag, "_ovf"}, 64'(overflow), 64'(e.ovf));
    end
  endtask

  // One transaction with out_ready high: wait for accept, measure latency, compare.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    int exp_lat;
    bit got;
`ifdef ALU_MUL_EN
    exp_lat = (op == 3'b111) ? 33 : 1;
`else
    exp_lat = 1;
`endif
    in_valid = 1'b1;
    alu_op   = op;
    operand1 = a;
    operand2 = b;
    got      = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (in_ready) got = 1'b1;
      else tick();
    end
    check({tag, "_accept"}, 64'(got), 64'd1);
    exp_q.push_back(model(op, a, b));
    tick();
    in_valid = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
    alu_op   = 3'($urandom_range(0, 7));
    lat      = 1;
    while (!out_valid && lat < 100) begin
      if (exp_lat > 1 && lat <= 32) check({tag, "_busy_nrdy"}, 64'({busy, in_ready}), 64'b10);
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    pop_check(tag);
  endtask

  vec_t dir_v[14];
  bit   stale;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operand1  = '0;
    operand2  = '0;
    alu_op    = '0;

    tick();
    tick();
    check("rst_state", 64'({out_valid, alu_out, overflow, busy, in_ready}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", 64'(in_ready), 64'd0);
    tick();
    check("rdy_after_edge", 64'(in_ready), 64'd1);

    dir_v[0]  = '{3'b101, 32'h7FFF_FFFF, 32'h0000_0001};
    dir_v[1]  = '{3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    dir_v[2]  = '{3'b110, 32'd32,        32'd34};
    dir_v[3]  = '{3'b100, 32'h8000_0000, 32'd4};
    dir_v[4]  = '{3'b100, 32'h8123_4567, 32'hFFFF_FFE0};
    dir_v[5]  = '{3'b000, 32'hF0F0_1234, 32'h0FF0_FF00};
    dir_v[6]  = '{3'b001, 32'hF0F0_1234, 32'h0FF0_FF00};
    dir_v[7]  = '{3'b010, 32'hF0F0_1234, 32'h0FF0_FF00};
    dir_v[8]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0001};
    dir_v[9]  = '{3'b011, 32'h0000_0001, 32'hFFFF_FFFF};
    dir_v[10] = '{3'b111, 32'hFFFF_FFFD, 32'h0000_0007};
    dir_v[11] = '{3'b111, 32'h0001_0000, 32'h0001_0000};
    dir_v[12] = '{3'b111, 32'h8000_0000, 32'h0000_0001};
    dir_v[13] = '{3'b111, 32'h8000_0000, 32'h8000_0000};
    for (int i = 0; i < 14; i++) do_op($sformatf("dir%0d", i), dir_v[i].op, dir_v[i].a, dir_v[i].b);

    for (int i = 0; i < 8; i++)
      do_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 6)), $urandom, $urandom);
    do_op("rnd_mul", 3'b111, $urandom_range(0, 65535), 32'hFFFF_0000 | $urandom_range(0, 65535));

    // Back-to-back: one op accepted per cycle while results drain.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      alu_op   = 3'(i + 3);
      operand1 = $urandom;
      operand2 = $urandom;
      check($sformatf("b2b%0d_rdy", i), 64'(in_ready), 64'd1);
      exp_q.push_back(model(alu_op, operand1, operand2));
      tick();
      check($sformatf("b2b%0d_vld", i), 64'(out_valid), 64'd1);
      pop_check($sformatf("b2b%0d", i));
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: ADD result held while a waiting XOR is refused.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_op    = 3'b101;
    operand1  = 32'd32;
    operand2  = 32'd34;
    check("bp_add_rdy", 64'(in_ready), 64'd1);
    exp_q.push_back(model(3'b101, 32'd32, 32'd34));
    tick();
    alu_op   = 3'b010;
    operand1 = 32'h0F0F_0F0F;
    operand2 = 32'h00FF_00FF;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d", k), 64'({out_valid, in_ready, alu_out, overflow}),
            64'({1'b1, 1'b0, 32'h0000_0042, 1'b0}));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 64'(in_ready), 64'd1);
    pop_check("bp_add");
    exp_q.push_back(model(3'b010, 32'h0F0F_0F0F, 32'h00FF_00FF));
    tick();
    in_valid = 1'b0;
    check("bp_xor_vld", 64'(out_valid), 64'd1);
    pop_check("bp_xor");
    tick();

    // Reset in the middle of a multiply.
    in_valid = 1'b1;
    alu_op   = 3'b111;
    operand1 = 32'hFFFF_FFFB;
    operand2 = 32'd9;
    check("rstmul_rdy", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
`ifdef ALU_MUL_EN
    check("rstmul_busy_before", 64'(busy), 64'd1);
`endif
    rst_n = 1'b0;
    #1;
    check("rstmul_async", 64'({out_valid, alu_out, busy, in_ready}), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rstmul_rdy_low", 64'(in_ready), 64'd0);
    tick();
    check("rstmul_rdy_high", 64'(in_ready), 64'd1);
    stale = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) stale = 1'b1;
      tick();
    end
    check("rstmul_no_stale", 64'(stale), 64'd0);
    do_op("post_rst", 3'b101, 32'hFFFF_FFFF, 32'h8000_0000);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
